// File: rtl/one_hot_dec_buf.sv
// Registered one-hot-to-binary decoder feeding a 2-entry output buffer with valid/ready on both sides.
// Define ONE_HOT_DEC_ERR_CNT_EN to build the saturating malformed-word counter behind err_cnt_o.
module one_hot_dec_buf #(
   parameter int BIN_W     = 4,
   parameter int ONE_HOT_W = 16,
   parameter int CNT_W     = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 valid_i,
   input  logic [ONE_HOT_W-1:0] one_hot_i,
   output logic                 ready_o,
   output logic                 valid_o,
   output logic [BIN_W-1:0]     bin_o,
   output logic                 err_o,
   input  logic                 ready_i,
   output logic [CNT_W-1:0]     err_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // Returns {bin, err}: lowest set bit index, err unless exactly one bit is set.
   function automatic logic [BIN_W:0] decode_one_hot(input logic [ONE_HOT_W-1:0] vec);
      logic [BIN_W-1:0] bin;
      logic             found;
      logic             multi;
      bin   = {BIN_W{1'b0}};
      found = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < ONE_HOT_W; i++) begin
         if (vec[i]) begin
            if (found) begin
               multi = 1'b1;
            end else begin
               found = 1'b1;
               bin   = BIN_W'(i);
            end
         end
      end
      return {bin, (~found) | multi};
   endfunction

   state_t           state_r, state_s;
   logic [BIN_W-1:0] head_bin_r, head_bin_s;
   logic             head_err_r, head_err_s;
   logic [BIN_W-1:0] tail_bin_r, tail_bin_s;
   logic             tail_err_r, tail_err_s;
   logic             ready_r;
   logic             valid_r;
   logic             push_s;
   logic             pop_s;
   logic [BIN_W-1:0] dec_bin_s;
   logic             dec_err_s;

   assign {dec_bin_s, dec_err_s} = decode_one_hot(one_hot_i);
   assign push_s = valid_i & ready_r;
   assign pop_s  = valid_r & ready_i;

   // Next buffer state and entry contents; the head is zeroed whenever the buffer drains.
   always_comb begin
      state_s    = state_r;
      head_bin_s = head_bin_r;
      head_err_s = head_err_r;
      tail_bin_s = tail_bin_r;
      tail_err_s = tail_err_r;
      case (state_r)
         ST_EMPTY: begin
            if (push_s) begin
               state_s    = ST_ONE;
               head_bin_s = dec_bin_s;
               head_err_s = dec_err_s;
            end else begin
               state_s = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (push_s && pop_s) begin
               head_bin_s = dec_bin_s;
               head_err_s = dec_err_s;
            end else if (push_s) begin
               state_s    = ST_FULL;
               tail_bin_s = dec_bin_s;
               tail_err_s = dec_err_s;
            end else if (pop_s) begin
               state_s    = ST_EMPTY;
               head_bin_s = {BIN_W{1'b0}};
               head_err_s = 1'b0;
            end else begin
               state_s = ST_ONE;
            end
         end
         ST_FULL: begin
            if (pop_s) begin
               state_s    = ST_ONE;
               head_bin_s = tail_bin_r;
               head_err_s = tail_err_r;
               tail_bin_s = {BIN_W{1'b0}};
               tail_err_s = 1'b0;
            end else begin
               state_s = ST_FULL;
            end
         end
         default: begin
            state_s    = ST_EMPTY;
            head_bin_s = {BIN_W{1'b0}};
            head_err_s = 1'b0;
            tail_bin_s = {BIN_W{1'b0}};
            tail_err_s = 1'b0;
         end
      endcase
   end

   // State and data registers; ready/valid are registered from the next state so ready_i never reaches ready_o.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= ST_EMPTY;
         head_bin_r <= {BIN_W{1'b0}};
         head_err_r <= 1'b0;
         tail_bin_r <= {BIN_W{1'b0}};
         tail_err_r <= 1'b0;
         ready_r    <= 1'b0;
         valid_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         head_bin_r <= head_bin_s;
         head_err_r <= head_err_s;
         tail_bin_r <= tail_bin_s;
         tail_err_r <= tail_err_s;
         ready_r    <= (state_s != ST_FULL);
         valid_r    <= (state_s != ST_EMPTY);
      end
   end

   assign ready_o = ready_r;
   assign valid_o = valid_r;
   assign bin_o   = head_bin_r;
   assign err_o   = head_err_r;

`ifdef ONE_HOT_DEC_ERR_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   logic [CNT_W-1:0] err_cnt_r;

   // Saturating count of accepted malformed words.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         err_cnt_r <= {CNT_W{1'b0}};
      end else if (push_s && dec_err_s && (err_cnt_r != CNT_MAX)) begin
         err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign err_cnt_o = err_cnt_r;
`else
   assign err_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_one_hot_dec_buf.sv
// Self-checking bench for one_hot_dec_buf: a queue-based reference model compared every cycle,
// plus literal expectations for ordering, backpressure, saturation and reset.
module tb_one_hot_dec_buf;
   localparam int BIN_W     = 4;
   localparam int ONE_HOT_W = 16;
   localparam int CNT_W     = 8;
`ifdef ONE_HOT_DEC_ERR_CNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic                 clk = 1'b0;
   logic                 reset_i = 1'b1;
   logic                 valid_i = 1'b0;
   logic [ONE_HOT_W-1:0] one_hot_i = '0;
   logic                 ready_i = 1'b0;
   logic                 ready_o;
   logic                 valid_o;
   logic [BIN_W-1:0]     bin_o;
   logic                 err_o;
   logic [CNT_W-1:0]     err_cnt_o;

   always #5 clk = ~clk;

   one_hot_dec_buf #(.BIN_W(BIN_W), .ONE_HOT_W(ONE_HOT_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .one_hot_i(one_hot_i),
      .ready_o(ready_o), .valid_o(valid_o), .bin_o(bin_o), .err_o(err_o),
      .ready_i(ready_i), .err_cnt_o(err_cnt_o)
   );

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   // reference model state
   logic [BIN_W:0] mq[$];
   int  m_cnt = 0;
   bit  m_ready = 1'b0;
   int  log_bin[$];
   int  log_err[$];

   function automatic logic [BIN_W:0] ref_dec(input logic [ONE_HOT_W-1:0] v);
      logic [ONE_HOT_W-1:0] iso;
      int b;
      iso = v & (~v + 16'd1);
      b = 0;
      for (int i = 0; i < ONE_HOT_W; i++)
         if (iso == (16'd1 << i)) b = i;
      return {BIN_W'(b), ($countones(v) != 1)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model update on each rising edge
   initial begin
      bit push, pop;
      logic [BIN_W:0] e;
      forever begin
         @(posedge clk);
         if (reset_i) begin
            mq.delete();
            m_cnt = 0;
            m_ready = 1'b0;
         end else begin
            push = valid_i && m_ready;
            pop  = (mq.size() != 0) && (ready_i === 1'b1);
            if (pop) begin
               e = mq.pop_front();
               log_bin.push_back(int'(e[BIN_W:1]));
               log_err.push_back(int'(e[0]));
            end
            if (push) begin
               e = ref_dec(one_hot_i);
               mq.push_back(e);
               if (e[0] && m_cnt < (2**CNT_W - 1)) m_cnt++;
            end
            m_ready = (mq.size() != 2);
         end
      end
   end

   // per-cycle comparison against the model
   initial begin
      logic [BIN_W:0] h;
      forever begin
         @(negedge clk);
         if (checking) begin
            h = (mq.size() != 0) ? mq[0] : '0;
            chk("ready_o", ready_o, m_ready);
            chk("valid_o", valid_o, mq.size() != 0);
            chk("bin_o", bin_o, h[BIN_W:1]);
            chk("err_o", err_o, h[0]);
            chk("err_cnt_o", err_cnt_o, CNT_ON ? m_cnt : 0);
         end
      end
   end

   task automatic send(input logic [ONE_HOT_W-1:0] w);
      int n;
      valid_i = 1'b1;
      one_hot_i = w;
      n = 0;
      forever begin
         @(negedge clk);
         if (ready_o === 1'b1) begin
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %0h not accepted after %0d cycles", w, n);
            break;
         end
      end
      valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int ks[20];
      logic [BIN_W:0] d;

      // model pins
      d = ref_dec(16'h0024); chk("ref_0024", d, {4'd2, 1'b1});
      d = ref_dec(16'h0000); chk("ref_0000", d, {4'd0, 1'b1});
      d = ref_dec(16'h8000); chk("ref_8000", d, {4'd15, 1'b0});

      // reset
      @(posedge clk);
      checking = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("rst_ready_low", ready_o, 1'b0);
      chk("rst_valid_low", valid_o, 1'b0);
      @(negedge clk);
      chk("ready_after_reset", ready_o, 1'b1);
      @(posedge clk); #1;

      // back-to-back walking ones
      ready_i = 1'b1;
      fork
         begin
            for (int k = 0; k < 16; k++) send(16'd1 << k);
         end
         begin
            @(negedge clk);
            chk("t1_no_valid_yet", valid_o, 1'b0);
            for (int k = 0; k < 16; k++) begin
               @(negedge clk);
               chk("t1_valid", valid_o, 1'b1);
               chk("t1_bin", bin_o, k);
               chk("t1_err", err_o, 1'b0);
            end
         end
      join
      idle(3);

      // malformed words
      base = log_bin.size();
      send(16'h0000);
      send(16'h0024);
      idle(3);
      chk("t2_bin0", log_bin[base], 0);
      chk("t2_err0", log_err[base], 1);
      chk("t2_bin1", log_bin[base+1], 2);
      chk("t2_err1", log_err[base+1], 1);
      chk("t2_cnt", err_cnt_o, CNT_ON ? 2 : 0);

      // backpressure
      ready_i = 1'b0;
      base = log_bin.size();
      send(16'h0010);
      send(16'h0100);
      valid_i = 1'b1;
      one_hot_i = 16'h1000;
      repeat (2) begin
         @(negedge clk);
         chk("t3_ready_low", ready_o, 1'b0);
         chk("t3_head", bin_o, 4);
         @(posedge clk); #1;
      end
      ready_i = 1'b1;
      send(16'h1000);
      idle(4);
      chk("t3_count", log_bin.size(), base + 3);
      chk("t3_out0", log_bin[base], 4);
      chk("t3_out1", log_bin[base+1], 8);
      chk("t3_out2", log_bin[base+2], 12);

      // random one-hot words with alternating ready_i
      base = log_bin.size();
      for (int i = 0; i < 20; i++) ks[i] = $urandom_range(0, 15);
      fork
         begin
            repeat (100) begin
               @(posedge clk); #1;
               ready_i = ~ready_i;
            end
         end
         begin
            for (int i = 0; i < 20; i++) send(16'd1 << ks[i]);
         end
      join
      ready_i = 1'b1;
      idle(4);
      chk("t4_count", log_bin.size(), base + 20);
      for (int i = 0; i < 20; i++) chk("t4_order", log_bin[base+i], ks[i]);

      // saturation
      for (int i = 0; i < 300; i++) send(16'h0003);
      idle(3);
      chk("t5_sat", err_cnt_o, CNT_ON ? 255 : 0);
      chk("t5_last_bin", log_bin[log_bin.size()-1], 0);
      chk("t5_last_err", log_err[log_err.size()-1], 1);

      // reset while full
      ready_i = 1'b0;
      send(16'h0001);
      send(16'h0002);
      @(negedge clk);
      chk("t6_full_valid", valid_o, 1'b1);
      chk("t6_full_ready", ready_o, 1'b0);
      @(posedge clk); #1;
      base = log_bin.size();
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      ready_i = 1'b1;
      @(negedge clk);
      chk("t6_valid_cleared", valid_o, 1'b0);
      chk("t6_cnt_cleared", err_cnt_o, 0);
      chk("t6_ready_low", ready_o, 1'b0);
      @(negedge clk);
      chk("t6_ready_back", ready_o, 1'b1);
      chk("t6_still_empty", valid_o, 1'b0);
      idle(5);
      chk("t6_nothing_emitted", log_bin.size(), base);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
